// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and default sizing for the multi-port register file.
//   rf_state_e - clear sequencer state (CLEAR after reset, RUN once storage is zeroed)
//   RF_*       - default parameter values used by reg_file_mp
package reg_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: one busy bit per register for decode-stage hazard detection.
//   sysclk   - clock, all updates on the rising edge
//   clr      - synchronous clear of every busy bit (highest priority)
//   set_en   - mark set_addr busy (a producer was issued)
//   set_addr - register being marked busy
//   clr_en   - mark clr_addr free (its producer wrote back)
//   clr_addr - register being freed
//   busy     - registered busy vector, bit i belongs to register i
// When a set and a clear hit the same register in one cycle the set wins:
// the newly issued producer supersedes the one that is writing back.
// With ZERO_REG != 0, register 0 can never become busy.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              sysclk,
  input  logic              clr,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] busy_next;
  logic             set_ok;

  assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

  // NOTE: busy_next gets its full default before any conditional update, so
  // no path through this block leaves a bit unassigned and no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    // Applied after the clear so a same-address set overrides it.
    if (set_ok) busy_next[set_addr] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge sysclk) begin
    if (clr) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with scoreboard.
//   sysclk     - clock, all state updates on the rising edge
//   rst        - synchronous, active-high reset; restarts the clear sequence
//   rd_addr    - NUM_RD packed read addresses, port k in slice k
//   rd_data    - NUM_RD packed read data, combinational
//   rd_busy    - busy bit of each read address, combinational
//   wr_en      - writeback strobe
//   wr_addr    - writeback address
//   wr_data    - writeback data
//   issue_en   - marks issue_addr busy
//   issue_addr - destination register of the issued instruction
//   ready      - registered, high once the storage has been zeroed
// After reset the storage is zeroed one entry per cycle so it can map onto a
// RAM without a bulk reset; reads report 0/not-busy until that finishes.
// Optional feature macro: REG_FILE_BYPASS_EN - forwards the writeback value
// (and the cleared busy state) to a read port in the cycle of the write.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     ready
);

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] clear_ptr, clear_ptr_next;
  logic              ready_next;
  logic              running;
  logic              wr_ok;
  logic [DEPTH-1:0]  busy;
  logic [DATA_W-1:0] regs [DEPTH];

  assign running = (state == RUN);
  assign wr_ok   = running && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Clear sequencer: state register plus next-state logic.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= CLEAR;
      clear_ptr <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      clear_ptr <= clear_ptr_next;
      ready     <= ready_next;
    end
  end

  always_comb begin
    state_next     = state;
    clear_ptr_next = clear_ptr;
    ready_next     = ready;
    unique case (state)
      CLEAR: begin
        clear_ptr_next = clear_ptr + 1'b1;
        if (clear_ptr == ADDR_W'(DEPTH - 1)) begin
          state_next = RUN;
          ready_next = 1'b1;
        end
      end
      RUN: ready_next = 1'b1;
      default: state_next = CLEAR;
    endcase
  end

  // NOTE: the storage array has no reset branch; reset only steers the clear
  // sequencer, which zeroes entries one per cycle so the array stays RAM-mappable.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      if (state == CLEAR) regs[clear_ptr] <= '0;
      else if (wr_ok)     regs[wr_addr]   <= wr_data;
    end
  end

  // Writebacks and issues are ignored while clearing; reset wipes the bits.
  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .sysclk   (sysclk),
    .clr      (rst),
    .set_en   (running && issue_en),
    .set_addr (issue_addr),
    .clr_en   (running && wr_en),
    .clr_addr (wr_addr),
    .busy     (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              blank;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr  = rd_addr[k*ADDR_W +: ADDR_W];
    // Entries not yet cleared and the hard-wired zero register read as 0.
    assign blank = !running || ((ZERO_REG != 0) && (addr == '0));

`ifdef REG_FILE_BYPASS_EN
    logic hit;
    // wr_ok already excludes the zero register and the CLEAR state.
    assign hit  = wr_ok && (wr_addr == addr);
    assign data = blank ? '0 : (hit ? wr_data : regs[addr]);
    // A forwarded value has no pending producer unless one issues right now.
    assign bsy  = blank ? 1'b0
                : (hit ? (issue_en && (issue_addr == addr)) : busy[addr]);
`else
    assign data = blank ? '0 : regs[addr];
    assign bsy  = blank ? 1'b0 : busy[addr];
`endif

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic              sysclk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sysclk = ~sysclk;

  reg_file_mp #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .ready      (ready)
  );

  typedef struct {
    logic                 we;
    logic [AW-1:0]        wa;
    logic [DW-1:0]        wd;
    logic                 ie;
    logic [AW-1:0]        ia;
    logic [NR-1:0][AW-1:0] ra;
    logic [NR-1:0][DW-1:0] ed;
    logic [NR-1:0]        eb;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic ie, input logic [AW-1:0] ia,
                              input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                              input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                              input logic [NR-1:0] eb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2; v.ed[3] = d3;
    v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] port_data(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  vec_t vecs[13];

  initial begin
    int n;
    idle();
    rd_addr = '0;
    rst = 1'b1;

    // 1. Clear sequencing, with writes/issues to x5 that must be ignored.
    repeat (3) step();
    @(negedge sysclk);
    check("ready_in_reset", {31'd0, ready}, 32'd0);
    check("busy_in_reset", {28'd0, rd_busy}, 32'd0);
    @(posedge sysclk); #1;
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hBAD0BAD0;
    issue_en = 1'b1; issue_addr = 5'd5;
    for (int k = 0; k < NR; k++) set_rd(k, AW'(5 + k));
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge sysclk);
      if (ready !== 1'b0) check($sformatf("ready_low_cyc%0d", i), {31'd0, ready}, 32'd0);
      if (rd_data !== '0) check($sformatf("clear_rd_zero_cyc%0d", i), port_data(0), 32'd0);
      if (rd_busy !== '0) check($sformatf("clear_busy_zero_cyc%0d", i), {28'd0, rd_busy}, 32'd0);
      step();
    end
    idle();
    @(negedge sysclk);
    check("ready_after_32", {31'd0, ready}, 32'd1);
    check("x5_after_clear", port_data(0), 32'd0);
    check("x5_busy_after_clear", {31'd0, rd_busy[0]}, 32'd0);

    // 2. Write/read with same-cycle behaviour depending on bypass.
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    set_rd(0, 5'd7);
    @(negedge sysclk);
`ifdef REG_FILE_BYPASS_EN
    check("x7_same_cycle", port_data(0), 32'hDEADBEEF);
`else
    check("x7_same_cycle", port_data(0), 32'h0);
`endif
    step();
    wr_data = 32'hCAFEF00D; issue_en = 1'b1; issue_addr = 5'd7;
    @(negedge sysclk);
`ifdef REG_FILE_BYPASS_EN
    check("x7_wr_issue_data", port_data(0), 32'hCAFEF00D);
    check("x7_wr_issue_busy", {31'd0, rd_busy[0]}, 32'd1);
`else
    check("x7_wr_issue_data", port_data(0), 32'hDEADBEEF);
    check("x7_wr_issue_busy", {31'd0, rd_busy[0]}, 32'd0);
`endif
    step();
    idle();
    @(negedge sysclk);
    check("x7_next_cycle", port_data(0), 32'hCAFEF00D);
    check("x7_set_wins", {31'd0, rd_busy[0]}, 32'd1);
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    @(negedge sysclk);
`ifdef REG_FILE_BYPASS_EN
    check("x7_wb_busy_same", {31'd0, rd_busy[0]}, 32'd0);
`else
    check("x7_wb_busy_same", {31'd0, rd_busy[0]}, 32'd1);
`endif
    step();
    idle();
    @(negedge sysclk);
    check("x7_wb_data", port_data(0), 32'h1);
    check("x7_wb_busy", {31'd0, rd_busy[0]}, 32'd0);
    step();

    // 3/4/6. Table: scoreboard, zero register, four independent ports.
    //            we  wa     wd            ie  ia     r0 r1 r2 r3     d0..d3                                         busy[3:0]
    vecs[0]  = mk(1, 5'd10, 32'hA5A5,     1, 5'd3,  0, 1, 2, 3,      0, 0, 0, 0,                                    4'b0000);
    vecs[1]  = mk(1, 5'd11, 32'h1111,     0, 5'd0,  10, 3, 0, 12,    32'hA5A5, 0, 0, 0,                             4'b0010);
    vecs[2]  = mk(1, 5'd3,  32'h12,       1, 5'd3,  10, 11, 12, 1,   32'hA5A5, 32'h1111, 0, 0,                      4'b0000);
    vecs[3]  = mk(1, 5'd12, 32'h3C3C,     0, 5'd0,  3, 10, 11, 3,    32'h12, 32'hA5A5, 32'h1111, 32'h12,            4'b1001);
    vecs[4]  = mk(1, 5'd3,  32'h99,       0, 5'd0,  12, 10, 12, 11,  32'h3C3C, 32'hA5A5, 32'h3C3C, 32'h1111,        4'b0000);
    vecs[5]  = mk(1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  3, 0, 3, 10,     32'h99, 0, 32'h99, 32'hA5A5,                   4'b0000);
    vecs[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  0, 0, 0, 0,      0, 0, 0, 0,                                    4'b0000);
    vecs[7]  = mk(0, 5'd0,  32'h0,        1, 5'd5,  5, 0, 5, 3,      0, 0, 0, 32'h99,                               4'b0000);
    vecs[8]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  5, 4, 5, 4,      0, 0, 0, 0,                                    4'b0101);
    vecs[9]  = mk(1, 5'd4,  32'h44,       1, 5'd5,  5, 10, 11, 12,   0, 32'hA5A5, 32'h1111, 32'h3C3C,               4'b0001);
    vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  4, 5, 4, 5,      32'h44, 0, 32'h44, 0,                          4'b1010);
    vecs[11] = mk(1, 5'd5,  32'h55,       0, 5'd0,  4, 3, 12, 10,    32'h44, 32'h99, 32'h3C3C, 32'hA5A5,            4'b0000);
    vecs[12] = mk(0, 5'd0,  32'h0,        0, 5'd0,  5, 5, 5, 5,      32'h55, 32'h55, 32'h55, 32'h55,                4'b0000);

    for (int i = 0; i < 13; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      issue_en = vecs[i].ie; issue_addr = vecs[i].ia;
      for (int k = 0; k < NR; k++) set_rd(k, vecs[i].ra[k]);
      @(negedge sysclk);
      for (int k = 0; k < NR; k++) begin
        check($sformatf("vec%0d_data%0d", i, k), port_data(k), vecs[i].ed[k]);
        check($sformatf("vec%0d_busy%0d", i, k), {31'd0, rd_busy[k]}, {31'd0, vecs[i].eb[k]});
      end
      step();
    end
    idle();

    // 5. Reset mid-RUN: busy x4 and x9=0x55, then restart the clear.
    issue_en = 1'b1; issue_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    step();
    idle();
    set_rd(0, 5'd9); set_rd(1, 5'd4);
    @(negedge sysclk);
    check("x9_before_rst", port_data(0), 32'h55);
    check("x4_busy_before_rst", {31'd0, rd_busy[1]}, 32'd1);
    step();
    rst = 1'b1;
    step();
    check("ready_mid_rst", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("rerun_clear_cycles", 32'(n), 32'd32);
    @(negedge sysclk);
    check("x9_after_rerun", port_data(0), 32'd0);
    check("x4_busy_after_rerun", {31'd0, rd_busy[1]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
